uart_rx_deserializer: RTL and testbench

Serial UART receiver for 8N1 frames. It recovers bytes from the asynchronous RX pin and presents them as a one-cycle strobe plus data byte. The outputs connect directly to the i_rx_data / i_rx_stb inputs of the wishbone UART buffer, which stores each byte in its receive ring buffer. It also flags framing errors and line breaks for debug and status use.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_deserializer.sv | 145 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, data width, baud divisor.
// Pure declarations; no latency, no flow control.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Integer clocks per bit; any fractional part becomes baud error on the line.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; 2-cycle latency, no flow control.
// Both flops reset to RESET_VAL so an idle-high line never reports a spurious edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: strobe 2+HALF_BIT+9*CLKS_PER_BIT+1 clocks after the start edge.
// No back-pressure: every byte is strobed once; framing errors pulse o_frame_err instead.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int I_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_uart_rx,
  output logic [UART_DATA_BITS-1:0] o_rx_data,
  output logic                      o_rx_stb,
  output logic                      o_frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(I_CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_baud_check
      $error("uart_rx_deserializer: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_uart_rx),
    .o_q    (rx_s)
  );

  rx_state_t                 state, state_d;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_d;
  logic [IDX_W-1:0]          bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg, shreg_d;
  logic [UART_DATA_BITS-1:0] rx_data_d;
  logic                      rx_stb_d;
  logic                      frame_err_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_rx_data   <= '0;
      o_rx_stb    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_d;
      clk_cnt     <= clk_cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      o_rx_data   <= rx_data_d;
      o_rx_stb    <= rx_stb_d;
      o_frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    clk_cnt_d   = clk_cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    rx_data_d   = o_rx_data;
    rx_stb_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      // Half a bit in, a high line means the edge was a glitch.
      START: begin
        if (clk_cnt == HALF_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end

      // Leaving at the stop-bit centre gives half a bit to catch a back-to-back start edge.
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rx_data_d = shreg;
            rx_stb_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed scoreboard bench for uart_rx_deserializer at 16 clocks per bit.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int CPB  = 16;
  localparam int LAT  = 2 + 8 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .I_CLOCK_FREQ(FREQ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_uart_rx  (rx),
    .o_rx_data  (rx_data),
    .o_rx_stb   (rx_stb),
    .o_frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned fall;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe or error pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rx_stb === 1'b1 || frame_err === 1'b1) begin
      if (rx_stb && frame_err) check("stb_err_exclusive", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, rx_stb, frame_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("output_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        if (!mon_e.is_err) check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
        check("latency", cyc - mon_e.fall, LAT);
      end
    end
  end

  // Bit j: 0 = start, 1..8 = data, 9 = stop. Modes 1/2 model a transmitter about 3% fast/slow;
  // steady 15- or 17-clock bits drift past a bit edge before the stop sample.
  function automatic int bit_len(input int mode, input int j);
    if (mode == 1) return (j % 2 == 0) ? 15 : 16;
    if (mode == 2) return (j % 2 == 0) ? 17 : 16;
    return CPB;
  endfunction

  task automatic drive_bit(input logic v, input int len);
    rx = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int mode);
    exp_t e;
    e.is_err = !stop_val;
    e.data   = b;
    e.fall   = cyc;
    sb.push_back(e);
    drive_bit(1'b0, bit_len(mode, 0));
    for (int i = 0; i < 8; i++) drive_bit(b[i], bit_len(mode, i + 1));
    drive_bit(stop_val, bit_len(mode, 9));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] aborted;
    aborted = 8'hC3;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_stb", {31'd0, rx_stb}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_state", {29'd0, dut.state}, {29'd0, IDLE});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain byte from idle.
    send_byte(8'h55, 1'b1, 0);
    drive_bit(1'b1, 20);

    // Low stop bit held as a break: one error pulse, data register untouched.
    send_byte(8'hA3, 1'b0, 0);
    drive_bit(1'b0, 3 * CPB);
    drive_bit(1'b1, 20);
    check("break_keeps_data", {24'd0, rx_data}, 32'h55);
    check("break_back_to_idle", {29'd0, dut.state}, {29'd0, IDLE});
    send_byte(8'h0F, 1'b1, 0);
    drive_bit(1'b1, 20);

    // Short glitch rejected at the start-bit centre.
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 20);
    check("glitch_idle", {29'd0, dut.state}, {29'd0, IDLE});
    send_byte(8'h3C, 1'b1, 0);
    drive_bit(1'b1, 20);

    // Back-to-back frames, no idle gap.
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h81, 1'b1, 0);
    drive_bit(1'b1, 20);

    // Reset in the middle of data bit 4; the aborted frame must stay silent.
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(aborted[i], CPB);
    drive_bit(aborted[4], 8);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_abort_state", {29'd0, dut.state}, {29'd0, IDLE});
    drive_bit(1'b1, 200);
    check("reset_abort_data", {24'd0, rx_data}, 32'h00);
    send_byte(8'h7E, 1'b1, 0);
    drive_bit(1'b1, 20);

    // Transmitter baud mismatch in both directions.
    send_byte(8'h5A, 1'b1, 1);
    drive_bit(1'b1, 20);
    send_byte(8'h5A, 1'b1, 2);
    drive_bit(1'b1, 40);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
